phase_generator_mc: RTL and testbench
=====================================

PHASE_GENERATOR_MC -- requirements
Module: phase_generator_mc

Interface
REQ-001 Parameter WIDTH, default 32, phase accumulator and delta width in bits (>=8).
REQ-002 Parameter CHANNELS, default 4, number of independent phase channels (2..64).
REQ-003 Parameter CH_BITS, default $clog2(CHANNELS), channel index width.
REQ-004 i_clk  in  1  the only clock; all state changes on its rising edge.
REQ-005 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 i_tick  in  1  sample strobe; starts one update sweep over all channels.
REQ-007 i_cfg_wr  in  1  configuration write strobe.
REQ-008 i_cfg_sel  in  1  0 = write delta, 1 = write phase (hard sync).
REQ-009 i_cfg_ch  in  CH_BITS  target channel of configuration write.
REQ-010 i_cfg_data  in  WIDTH  delta or phase value to write.
REQ-011 o_phase  out  WIDTH  updated phase of channel o_ch.
REQ-012 o_ch  out  CH_BITS  channel index of current output.
REQ-013 o_valid  out  1  o_phase/o_ch/o_wrap valid this cycle.
REQ-014 o_wrap  out  1  accumulation of o_ch carried out of WIDTH bits.
REQ-015 o_busy  out  1  sweep in progress.
REQ-016 o_overrun  out  1  one-cycle pulse: i_tick ignored because sweep still active.

Function
REQ-017 Per channel state SHALL be phase[c] and delta[c], each WIDTH bits, held in registers or RAM; one shared adder.
REQ-018 FSM SHALL have states IDLE and SWEEP; counter idx of CH_BITS bits.
REQ-019 IDLE: i_tick=1 -> SWEEP, idx=0; else remain IDLE.
REQ-020 SWEEP, each cycle: {carry, sum} = phase[idx] + delta[idx] (WIDTH+1 bits); phase[idx] <= sum modulo 2^WIDTH.
REQ-021 Outputs SHALL be registered: cycle after processing idx, o_valid=1, o_ch=idx, o_phase=sum, o_wrap=carry.
REQ-022 SWEEP: idx==CHANNELS-1 -> IDLE after that cycle; else idx increments; idx never exceeds CHANNELS-1 for non-power-of-2 CHANNELS.
REQ-023 Latency: i_tick at cycle T -> channel k output at cycle T+2+k; full sweep = CHANNELS cycles; o_busy=1 cycles T+1..T+CHANNELS.
REQ-024 i_tick while in SWEEP, or in the final SWEEP cycle, SHALL be dropped and o_overrun pulsed for one cycle the cycle after; back-to-back tick at exactly T+CHANNELS+1 or later is accepted.
REQ-025 o_valid=0 when not outputting; o_phase/o_ch/o_wrap hold last value then.
REQ-026 Delta write (i_cfg_sel=0): delta[i_cfg_ch] <= i_cfg_data next edge; if that channel is processed the same cycle, old delta SHALL be used.
REQ-027 Phase write (i_cfg_sel=1): phase[i_cfg_ch] <= i_cfg_data; if same channel processed same cycle, write SHALL win over accumulation result; output still shows computed sum.
REQ-028 Writes SHALL be accepted in any state, every cycle; i_cfg_ch >= CHANNELS SHALL be ignored.
REQ-029 Delta 0 SHALL hold phase constant; delta 2^(WIDTH-1) SHALL toggle MSB each sweep.

Reset
REQ-030 i_rst_n=0 SHALL immediately clear: FSM IDLE, idx=0, all phase[] and delta[] = 0, o_phase=0, o_ch=0, o_valid=0, o_wrap=0, o_busy=0, o_overrun=0.
REQ-031 Reset mid-sweep SHALL abort the sweep with no further o_valid; first i_tick after deassertion starts a fresh sweep.
REQ-032 Inputs SHALL be ignored while i_rst_n=0; deassertion assumed synchronous to i_clk.

Verification
REQ-033 WIDTH=32, CHANNELS=4; delta[0..3]=1,2,3,4; i_tick once -> o_valid 4 cycles, o_ch 0..3, o_phase 1,2,3,4, o_wrap=0.
REQ-034 phase[2]=0xFFFFFFFE via cfg, delta[2]=3, tick -> ch2 o_phase=0x00000001, o_wrap=1; other channels o_wrap=0.
REQ-035 tick at T and T+2 -> one sweep only, o_overrun pulse at T+3; tick at T+5 -> second sweep, o_phase doubled.
REQ-036 Phase write to ch1=0x100 in same cycle ch1 processed -> o_phase shows old sum; next sweep ch1 output = 0x100+delta[1].
REQ-037 Assert i_rst_n=0 during ch2 of sweep -> all outputs 0 within same cycle, no more o_valid; after release tick -> all channels output 0.
REQ-038 CHANNELS=3 (non-power-of-2) -> o_ch sequence 0,1,2 then IDLE; cfg write to ch3 has no effect.

Source files
------------

// File: rtl/phase_generator_mc.sv
// Multi-channel phase accumulator: one i_tick sweeps every channel through a
// single shared adder, one channel per cycle, with registered per-channel results.
module phase_generator_mc #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CH_BITS  = $clog2(CHANNELS)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_tick,
    input  logic               i_cfg_wr,
    input  logic               i_cfg_sel,
    input  logic [CH_BITS-1:0] i_cfg_ch,
    input  logic [WIDTH-1:0]   i_cfg_data,
    output logic [WIDTH-1:0]   o_phase,
    output logic [CH_BITS-1:0] o_ch,
    output logic               o_valid,
    output logic               o_wrap,
    output logic               o_busy,
    output logic               o_overrun
);

    localparam logic [CH_BITS-1:0] LAST_IDX = CH_BITS'(CHANNELS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CH_BITS-1:0] r_idx;
    logic [CH_BITS-1:0] w_next_idx;
    logic               w_overrun;
    logic               w_busy_next;

    logic [WIDTH-1:0]   r_phase [CHANNELS];
    logic [WIDTH-1:0]   r_delta [CHANNELS];
    logic [WIDTH:0]     w_sum;
    logic               w_cfg_hit;

    logic [WIDTH-1:0]   r_o_phase;
    logic [CH_BITS-1:0] r_o_ch;
    logic               r_o_valid;
    logic               r_o_wrap;
    logic               r_busy;
    logic               r_overrun;

    // Shared adder; the extra top bit is the wrap (carry out).
    assign w_sum     = {1'b0, r_phase[r_idx]} + {1'b0, r_delta[r_idx]};
    assign w_cfg_hit = i_cfg_wr && (32'(i_cfg_ch) < CHANNELS);

    // Sweep FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_idx     <= w_next_idx;
            r_busy    <= w_busy_next;
            r_overrun <= w_overrun;
        end
    end

    // Next-state logic; a tick seen during any sweep cycle is dropped and flagged.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_overrun    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_tick) begin
                    w_next_state = SWEEP;
                    w_next_idx   = '0;
                end
            end
            SWEEP: begin
                w_overrun = i_tick;
                if (r_idx == LAST_IDX) begin
                    w_next_state = IDLE;
                    w_next_idx   = '0;
                end else begin
                    w_next_idx = r_idx + CH_BITS'(1);
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_idx   = '0;
            end
        endcase
        w_busy_next = (w_next_state == SWEEP);
    end

    // Channel state and registered outputs; a config write issued later in
    // program order overrides the accumulation result for the same channel.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                r_phase[i] <= '0;
                r_delta[i] <= '0;
            end
            r_o_phase <= '0;
            r_o_ch    <= '0;
            r_o_valid <= 1'b0;
            r_o_wrap  <= 1'b0;
        end else begin
            r_o_valid <= 1'b0;
            if (r_state == SWEEP) begin
                r_phase[r_idx] <= w_sum[WIDTH-1:0];
                r_o_phase      <= w_sum[WIDTH-1:0];
                r_o_ch         <= r_idx;
                r_o_wrap       <= w_sum[WIDTH];
                r_o_valid      <= 1'b1;
            end
            if (w_cfg_hit) begin
                if (i_cfg_sel) begin
                    r_phase[i_cfg_ch] <= i_cfg_data;
                end else begin
                    r_delta[i_cfg_ch] <= i_cfg_data;
                end
            end
        end
    end

    assign o_phase   = r_o_phase;
    assign o_ch      = r_o_ch;
    assign o_valid   = r_o_valid;
    assign o_wrap    = r_o_wrap;
    assign o_busy    = r_busy;
    assign o_overrun = r_overrun;

endmodule

// File: tb/tb_phase_generator_mc.sv
// Bench for phase_generator_mc: table-driven sweeps with a scoreboard queue, plus
// hand sequences for write collisions, overrun, mid-sweep reset and 3 channels.
module tb_phase_generator_mc;

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] ph;
        logic        wrap;
    } exp_t;

    typedef struct {
        logic [31:0] delta  [4];
        logic        ph_wr;
        logic [1:0]  ph_ch;
        logic [31:0] ph_val;
        logic [31:0] exp_ph [4];
        logic [3:0]  exp_wrap;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_tick, i_cfg_wr, i_cfg_sel;
    logic [1:0]  i_cfg_ch;
    logic [31:0] i_cfg_data;
    logic [31:0] o_phase;
    logic [1:0]  o_ch;
    logic        o_valid, o_wrap, o_busy, o_overrun;

    logic        d3_tick, d3_cfg_wr, d3_cfg_sel;
    logic [1:0]  d3_cfg_ch;
    logic [31:0] d3_cfg_data;
    logic [31:0] d3_phase;
    logic [1:0]  d3_ch;
    logic        d3_valid, d3_wrap, d3_busy, d3_overrun;

    exp_t        sb_q [$];
    exp_t        mon_e;
    vec_t        tbl [4];
    logic [31:0] m_phase [4];
    logic [31:0] m_delta [4];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    phase_generator_mc #(.WIDTH(32), .CHANNELS(4)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick(i_tick), .i_cfg_wr(i_cfg_wr),
        .i_cfg_sel(i_cfg_sel), .i_cfg_ch(i_cfg_ch), .i_cfg_data(i_cfg_data),
        .o_phase(o_phase), .o_ch(o_ch), .o_valid(o_valid), .o_wrap(o_wrap),
        .o_busy(o_busy), .o_overrun(o_overrun)
    );

    phase_generator_mc #(.WIDTH(32), .CHANNELS(3)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick(d3_tick), .i_cfg_wr(d3_cfg_wr),
        .i_cfg_sel(d3_cfg_sel), .i_cfg_ch(d3_cfg_ch), .i_cfg_data(d3_cfg_data),
        .o_phase(d3_phase), .o_ch(d3_ch), .o_valid(d3_valid), .o_wrap(d3_wrap),
        .o_busy(d3_busy), .o_overrun(d3_overrun)
    );

    // Scoreboard: every o_valid pops one expected record.
    always @(negedge clk) begin
        if (rst_n && o_valid) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: got ch=%0d phase=%h, required no output", o_ch, o_phase);
            end else begin
                mon_e = sb_q.pop_front();
                if (o_ch !== mon_e.ch || o_phase !== mon_e.ph || o_wrap !== mon_e.wrap) begin
                    n_err++;
                    $display("FAIL sweep_out: got ch=%0d phase=%h wrap=%0b, required ch=%0d phase=%h wrap=%0b",
                             o_ch, o_phase, o_wrap, mon_e.ch, mon_e.ph, mon_e.wrap);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_phase"},   o_phase, 32'h0);
        chk({tag, "_ch"},      32'(o_ch), 32'h0);
        chk({tag, "_valid"},   32'(o_valid), 32'h0);
        chk({tag, "_wrap"},    32'(o_wrap), 32'h0);
        chk({tag, "_busy"},    32'(o_busy), 32'h0);
        chk({tag, "_overrun"}, 32'(o_overrun), 32'h0);
    endtask

    task automatic model_sweep(input bit push);
        logic [32:0] s;
        for (int c = 0; c < 4; c++) begin
            s = {1'b0, m_phase[c]} + {1'b0, m_delta[c]};
            if (push) sb_q.push_back('{ch: 2'(c), ph: s[31:0], wrap: s[32]});
            m_phase[c] = s[31:0];
        end
    endtask

    task automatic cfg_wr(input logic sel, input logic [1:0] ch, input logic [31:0] data);
        i_cfg_wr = 1'b1; i_cfg_sel = sel; i_cfg_ch = ch; i_cfg_data = data;
        if (sel) m_phase[ch] = data;
        else     m_delta[ch] = data;
        step();
        i_cfg_wr = 1'b0;
    endtask

    task automatic cfg3(input logic sel, input logic [1:0] ch, input logic [31:0] data);
        d3_cfg_wr = 1'b1; d3_cfg_sel = sel; d3_cfg_ch = ch; d3_cfg_data = data;
        step();
        d3_cfg_wr = 1'b0;
    endtask

    task automatic do_tick(input bit push);
        i_tick = 1'b1;
        model_sweep(push);
        step();
        i_tick = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0 && !o_busy && !o_valid) done = 1'b1;
        end
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL %s_drain: got %0d pending outputs after timeout, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic fill(input int v, input logic [31:0] d0, d1, d2, d3,
                        input logic pw, input logic [1:0] pc, input logic [31:0] pv,
                        input logic [31:0] e0, e1, e2, e3, input logic [3:0] ew);
        tbl[v].delta[0] = d0; tbl[v].delta[1] = d1; tbl[v].delta[2] = d2; tbl[v].delta[3] = d3;
        tbl[v].ph_wr = pw; tbl[v].ph_ch = pc; tbl[v].ph_val = pv;
        tbl[v].exp_ph[0] = e0; tbl[v].exp_ph[1] = e1; tbl[v].exp_ph[2] = e2; tbl[v].exp_ph[3] = e3;
        tbl[v].exp_wrap = ew;
    endtask

    initial begin
        // Cumulative sweeps from reset: basic deltas, wrap on ch2, delta 0 hold, MSB toggle.
        fill(0, 32'd1, 32'd2, 32'd3, 32'd4, 1'b0, 2'd0, 32'h0,
             32'd1, 32'd2, 32'd3, 32'd4, 4'b0000);
        fill(1, 32'd1, 32'd2, 32'd3, 32'd4, 1'b1, 2'd2, 32'hFFFF_FFFE,
             32'd2, 32'd4, 32'd1, 32'd8, 4'b0100);
        fill(2, 32'd0, 32'h8000_0000, 32'd5, 32'd0, 1'b0, 2'd0, 32'h0,
             32'd2, 32'h8000_0004, 32'd6, 32'd8, 4'b0000);
        fill(3, 32'd0, 32'h8000_0000, 32'd5, 32'd0, 1'b0, 2'd0, 32'h0,
             32'd2, 32'h0000_0004, 32'hB, 32'd8, 4'b0010);

        rst_n = 1'b0;
        i_tick = 1'b0; i_cfg_wr = 1'b0; i_cfg_sel = 1'b0; i_cfg_ch = 2'd0; i_cfg_data = 32'h0;
        d3_tick = 1'b0; d3_cfg_wr = 1'b0; d3_cfg_sel = 1'b0; d3_cfg_ch = 2'd0; d3_cfg_data = 32'h0;
        for (int c = 0; c < 4; c++) begin m_phase[c] = 32'h0; m_delta[c] = 32'h0; end
        #2;
        chk_zero_outputs("reset");
        step(); step();
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 4; v++) begin
            for (int c = 0; c < 4; c++) cfg_wr(1'b0, 2'(c), tbl[v].delta[c]);
            if (tbl[v].ph_wr) cfg_wr(1'b1, tbl[v].ph_ch, tbl[v].ph_val);
            i_tick = 1'b1;
            for (int c = 0; c < 4; c++)
                sb_q.push_back('{ch: 2'(c), ph: tbl[v].exp_ph[c], wrap: tbl[v].exp_wrap[c]});
            model_sweep(1'b0);
            step();
            i_tick = 1'b0;
            wait_drain("table");
        end

        // Phase write to ch1 and delta write to ch2 in the cycles those channels are processed.
        step();
        do_tick(1'b1);
        step();
        cfg_wr(1'b1, 2'd1, 32'h100);
        cfg_wr(1'b0, 2'd2, 32'h1000);
        wait_drain("collide");
        step();
        do_tick(1'b1);
        wait_drain("collide_next");

        // Reset while ch2 is being processed; tick and cfg held during reset are ignored.
        step();
        do_tick(1'b1);
        step(); step();
        #5;
        rst_n = 1'b0;
        i_tick = 1'b1; i_cfg_wr = 1'b1; i_cfg_sel = 1'b0; i_cfg_ch = 2'd0; i_cfg_data = 32'h55;
        #1;
        chk_zero_outputs("midreset");
        sb_q.delete();
        for (int c = 0; c < 4; c++) begin m_phase[c] = 32'h0; m_delta[c] = 32'h0; end
        step(); step();
        chk("reset_hold_busy", 32'(o_busy), 32'h0);
        i_tick = 1'b0; i_cfg_wr = 1'b0;
        rst_n = 1'b1;
        step();
        do_tick(1'b1);
        wait_drain("post_reset");

        // Overrun: ticks at T+2 and T+4 dropped, tick at T+5 accepted.
        for (int c = 0; c < 4; c++) cfg_wr(1'b0, 2'(c), 32'(c + 5));
        do_tick(1'b1);
        step();
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
        @(negedge clk);
        chk("ovr_T3_overrun", 32'(o_overrun), 32'h1);
        chk("ovr_T3_busy", 32'(o_busy), 32'h1);
        step();
        i_tick = 1'b1;
        @(negedge clk);
        chk("ovr_T4_overrun", 32'(o_overrun), 32'h0);
        chk("ovr_T4_busy", 32'(o_busy), 32'h1);
        step();
        model_sweep(1'b1);
        @(negedge clk);
        chk("ovr_T5_overrun", 32'(o_overrun), 32'h1);
        chk("ovr_T5_busy", 32'(o_busy), 32'h0);
        step();
        i_tick = 1'b0;
        @(negedge clk);
        chk("ovr_T6_overrun", 32'(o_overrun), 32'h0);
        chk("ovr_T6_busy", 32'(o_busy), 32'h1);
        wait_drain("overrun");

        // Three-channel instance: writes to ch3 must not land anywhere.
        step();
        cfg3(1'b0, 2'd0, 32'd10);
        cfg3(1'b0, 2'd1, 32'd20);
        cfg3(1'b0, 2'd2, 32'd30);
        cfg3(1'b0, 2'd3, 32'h999);
        cfg3(1'b1, 2'd3, 32'h777);
        for (int s = 1; s <= 2; s++) begin
            d3_tick = 1'b1;
            step();
            d3_tick = 1'b0;
            for (int k = 0; k < 3; k++) begin
                step();
                chk("ch3_valid", 32'(d3_valid), 32'h1);
                chk("ch3_ch", 32'(d3_ch), 32'(k));
                chk("ch3_phase", d3_phase, 32'((k + 1) * 10 * s));
                chk("ch3_wrap", 32'(d3_wrap), 32'h0);
            end
            step();
            chk("ch3_end_valid", 32'(d3_valid), 32'h0);
            chk("ch3_end_busy", 32'(d3_busy), 32'h0);
        end

        chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
